// File: rtl/spi_clk_pkg.sv
// Shared definitions for the SPI clock generator.
// Contents:
//   sck_state_t  - state of the gated serial clock controller (IDLE/RUN/STOP)
//   DEF_*_HALF   - default half-period lengths in clk50M cycles
//   cnt_width()  - counter width needed for a given half-period length
package spi_clk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } sck_state_t;

    localparam int DEF_CLK_HALF = 1;   // 25 MHz from 50 MHz
    localparam int DEF_SCK_HALF = 2;   // 12.5 MHz from 50 MHz

    // A counter spanning 0..half-1 needs at least one bit, even when half is 1.
    function automatic int cnt_width(input int half);
        return (half > 1) ? $clog2(half) : 1;
    endfunction

endpackage

// File: rtl/clk_div_half.sv
// Half-period counter with a toggling phase output.
// Ports:
//   clk50M   in   source clock, rising-edge logic
//   rst_n    in   asynchronous active-low reset (counter and phase to 0)
//   cnt_en   in   advance the counter this cycle
//   cnt_clr  in   force the counter to 0 (takes priority over cnt_en)
//   wrap     out  high in the cycle the counter sits on its last value while
//                 enabled, i.e. the edge that will toggle phase
//   phase    out  registered phase bit, toggles once every HALF enabled cycles
module clk_div_half
    import spi_clk_pkg::*;
#(
    parameter int HALF = 1              // must be >= 1
) (
    input  logic clk50M,
    input  logic rst_n,
    input  logic cnt_en,
    input  logic cnt_clr,
    output logic wrap,
    output logic phase
);

    localparam int              CW   = cnt_width(HALF);
    localparam logic [CW-1:0]   LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    assign wrap = cnt_en && !cnt_clr && (cnt == LAST);

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt_clr) begin
            cnt   <= '0;
        end else if (cnt_en) begin
            if (cnt == LAST) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt   <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_clk_gen.sv
// SPI clock generator: free-running divided system clock plus a gated SPI
// serial clock with glitch-free start and stop.
// Ports:
//   clk50M     in   50 MHz board clock, all logic on its rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   request for sck to run, sampled on clk50M rising edge
//   clk        out  free-running clock, half-period CLK_HALF clk50M cycles
//   sck        out  gated SPI clock, half-period SCK_HALF cycles, idles at CPOL
//   sck_lead   out  registered strobe in the cycle sck leaves CPOL
//   sck_trail  out  registered strobe in the cycle sck returns to CPOL
module spi_clk_gen
    import spi_clk_pkg::*;
#(
    parameter int CLK_HALF = DEF_CLK_HALF,  // must be >= 1
    parameter int SCK_HALF = DEF_SCK_HALF,  // must be >= 1
    parameter bit CPOL     = 1'b0
) (
    input  logic clk50M,
    input  logic rst_n,
    input  logic enable,
    output logic clk,
    output logic sck,
    output logic sck_lead,
    output logic sck_trail
);

    sck_state_t state;

    logic clk_phase;
    logic clk_wrap_unused;
    logic sck_run;
    logic sck_wrap;
    logic sck_phase;
    logic sck_phase_nxt;

    // System clock divider: always counting, never cleared.
    clk_div_half #(
        .HALF    (CLK_HALF)
    ) u_clk_div (
        .clk50M  (clk50M),
        .rst_n   (rst_n),
        .cnt_en  (1'b1),
        .cnt_clr (1'b0),
        .wrap    (clk_wrap_unused),
        .phase   (clk_phase)
    );

    // Serial clock divider: held at 0 in IDLE so every start begins a fresh
    // full half-period. STOP is only ever occupied with the phase away from
    // idle, so any toggle there is the one that brings sck back to CPOL.
    assign sck_run = (state != IDLE);

    clk_div_half #(
        .HALF    (SCK_HALF)
    ) u_sck_div (
        .clk50M  (clk50M),
        .rst_n   (rst_n),
        .cnt_en  (sck_run),
        .cnt_clr (!sck_run),
        .wrap    (sck_wrap),
        .phase   (sck_phase)
    );

    assign sck_phase_nxt = sck_phase ^ sck_wrap;

    assign clk = clk_phase;
    // Phase resets to 0 asynchronously, so sck snaps to CPOL on reset.
    assign sck = CPOL ^ sck_phase;

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sck_lead  <= 1'b0;
            sck_trail <= 1'b0;
        end else begin
            // Strobes land on the same edge as the phase toggle they describe.
            sck_lead  <= sck_wrap && !sck_phase;
            sck_trail <= sck_wrap &&  sck_phase;

            case (state)
                IDLE: begin
                    if (enable)
                        state <= RUN;
                end
                RUN: begin
                    // Stopping with sck already back at idle needs no further
                    // toggle; otherwise finish the active half-period in STOP.
                    if (!enable)
                        state <= sck_phase_nxt ? STOP : IDLE;
                end
                STOP: begin
                    if (enable)
                        state <= RUN;
                    else if (!sck_phase_nxt)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_clk_gen.sv
// Directed bench for spi_clk_gen: a default-parameter instance and a
// SCK_HALF=3 / CLK_HALF=2 / CPOL=1 instance driven from a shared clk50M.
module tb_spi_clk_gen;
    import spi_clk_pkg::*;

    logic clk50M = 1'b0;
    logic rst_n, enable;
    logic clk, sck, sck_lead, sck_trail;
    logic rst2_n, en2;
    logic clk2, sck2, lead2, trail2;

    int vectors     = 0;
    int miscompares = 0;
    int leads, trails;
    logic exp_s, exp_l, exp_t;

    // {sck, sck_lead, sck_trail} after each edge U0..U8 of the stop/restart test
    logic [2:0] tbl_rs [9] = '{3'b000, 3'b000, 3'b110, 3'b100, 3'b001,
                               3'b000, 3'b110, 3'b100, 3'b001};
    // Second instance, edges 1..10 after reset release with enable high
    logic       tbl_c2 [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0] tbl_s2 [10] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b000,
                                3'b000, 3'b101, 3'b100, 3'b100, 3'b010};

    always #10 clk50M = ~clk50M;

    spi_clk_gen #(
        .CLK_HALF  (1),
        .SCK_HALF  (2),
        .CPOL      (1'b0)
    ) dut (
        .clk50M    (clk50M),
        .rst_n     (rst_n),
        .enable    (enable),
        .clk       (clk),
        .sck       (sck),
        .sck_lead  (sck_lead),
        .sck_trail (sck_trail)
    );

    spi_clk_gen #(
        .CLK_HALF  (2),
        .SCK_HALF  (3),
        .CPOL      (1'b1)
    ) dut2 (
        .clk50M    (clk50M),
        .rst_n     (rst2_n),
        .enable    (en2),
        .clk       (clk2),
        .sck       (sck2),
        .sck_lead  (lead2),
        .sck_trail (trail2)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk50M);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        enable = 1'b0;
        en2    = 1'b0;
        repeat (3) step;

        // Reset state
        check("rst_clk",   8'(clk), 8'd0);
        check("rst_sck",   8'(sck), 8'd0);
        check("rst_strb",  8'({sck_lead, sck_trail}), 8'd0);
        check("rst_state", 8'(dut.state), 8'(IDLE));
        check("rst2_sck",  8'(sck2), 8'd1);
        check("rst2_clk",  8'(clk2), 8'd0);

        // Free-running clk with enable low: toggles every edge, sck quiet
        rst_n = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step;
            check("idle_clk", 8'(clk), 8'(k % 2));
            check("idle_sck", 8'({sck, sck_lead, sck_trail}), 8'd0);
        end

        // Continuous run: edge S0 samples enable, first rise at S2, period 4
        enable = 1'b1;
        leads  = 0;
        trails = 0;
        for (int k = 0; k <= 60; k++) begin
            step;
            exp_s = (k >= 2) && (((k - 2) % 4) < 2);
            exp_l = (k >= 2) && (((k - 2) % 4) == 0);
            exp_t = (k >= 4) && (((k - 2) % 4) == 2);
            check("run_sck", 8'({sck, sck_lead, sck_trail}), 8'({exp_s, exp_l, exp_t}));
            leads  += int'(sck_lead);
            trails += int'(sck_trail);
        end
        check("lead_cnt",  8'(leads),  8'd15);
        check("trail_cnt", 8'(trails), 8'd15);

        step;
        check("pre_stop_low",  8'({sck, sck_lead, sck_trail}), 8'b000);
        step;
        check("pre_stop_rise", 8'({sck, sck_lead, sck_trail}), 8'b110);

        // Drop enable at the start of a high phase: finish it, fall once, idle
        enable = 1'b0;
        step;
        check("stop_hold",  8'({sck, sck_lead, sck_trail}), 8'b100);
        check("stop_state", 8'(dut.state), 8'(STOP));
        step;
        check("stop_fall",  8'({sck, sck_lead, sck_trail}), 8'b001);
        check("stop_idle",  8'(dut.state), 8'(IDLE));
        for (int k = 0; k < 6; k++) begin
            step;
            check("stop_quiet", 8'({sck, sck_lead, sck_trail}), 8'b000);
        end

        // Restart, then drop and re-raise enable inside one high phase
        enable = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step;
            check("restart", 8'({sck, sck_lead, sck_trail}), 8'(tbl_rs[k]));
            if (k == 2) enable = 1'b0;
            if (k == 3) enable = 1'b1;
        end

        // Asynchronous reset between edges while sck is high
        step;
        check("pre_rst_low",  8'({sck, sck_lead, sck_trail}), 8'b000);
        step;
        check("pre_rst_rise", 8'({sck, sck_lead, sck_trail}), 8'b110);
        #4;
        rst_n = 1'b0;
        #1;
        check("arst_sck",  8'(sck), 8'd0);
        check("arst_clk",  8'(clk), 8'd0);
        check("arst_lead", 8'(sck_lead), 8'd0);
        step;
        check("arst_state", 8'(dut.state), 8'(IDLE));
        rst_n = 1'b1;
        step;
        check("rel_clk1", 8'(clk), 8'd1);
        check("rel_sck1", 8'({sck, sck_lead, sck_trail}), 8'b000);
        check("rel_state", 8'(dut.state), 8'(RUN));
        step;
        check("rel_clk2", 8'(clk), 8'd0);
        check("rel_sck2", 8'({sck, sck_lead, sck_trail}), 8'b000);
        step;
        check("rel_clk3", 8'(clk), 8'd1);
        check("rel_sck3", 8'({sck, sck_lead, sck_trail}), 8'b110);

        // Second instance: CPOL=1, 3-cycle sck phases, clk toggles every 2
        rst2_n = 1'b1;
        en2    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step;
            check("p2_clk", 8'(clk2), 8'(tbl_c2[k]));
            check("p2_sck", 8'({sck2, lead2, trail2}), 8'(tbl_s2[k]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
